// File: rtl/bp_me_pkg.sv
// Shared memory-message types for the CCE memory interface: message and size
// encodings, responder states, and the packed message layout macro.
package bp_me_pkg;

  typedef enum logic [2:0] {
    e_mem_msg_rd    = 3'd0,
    e_mem_msg_wr    = 3'd1,
    e_mem_msg_uc_rd = 3'd2,
    e_mem_msg_uc_wr = 3'd3,
    e_mem_msg_pre   = 3'd4
  } bp_mem_msg_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1   = 3'd0,
    e_mem_msg_size_2   = 3'd1,
    e_mem_msg_size_4   = 3'd2,
    e_mem_msg_size_8   = 3'd3,
    e_mem_msg_size_16  = 3'd4,
    e_mem_msg_size_32  = 3'd5,
    e_mem_msg_size_64  = 3'd6,
    e_mem_msg_size_128 = 3'd7
  } bp_mem_msg_size_e;

  typedef enum logic [1:0] {
    e_reset  = 2'd0,
    e_ready  = 2'd1,
    e_access = 2'd2,
    e_resp   = 2'd3
  } bp_mem_resp_state_e;

  function automatic int bp_mem_msg_width(input int paddr_width, input int block_width,
                                          input int payload_width);
    return 6 + payload_width + paddr_width + block_width;
  endfunction

endpackage

// Message layout shared by the UCE, victim cache and this responder (MSB first).
`define DECLARE_BP_MEM_IF(paddr_width_mp, block_width_mp, payload_width_mp) \
  typedef struct packed { \
    bp_me_pkg::bp_mem_msg_e      msg_type; \
    bp_me_pkg::bp_mem_msg_size_e size; \
    logic [payload_width_mp-1:0] payload; \
    logic [paddr_width_mp-1:0]   addr; \
    logic [block_width_mp-1:0]   data; \
  } bp_mem_msg_s;

// File: rtl/bp_mem_responder_storage.sv
// Single-port block RAM with per-byte write enables and a registered read port.
module bp_mem_responder_storage #(
  parameter int els_p   = 256,
  parameter int width_p = 512,
  localparam int lg_els_lp = $clog2(els_p),
  localparam int bytes_lp  = width_p / 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [lg_els_lp-1:0] addr,
  input  logic [width_p-1:0]   wdata,
  input  logic [bytes_lp-1:0]  wmask,
  output logic [width_p-1:0]   rdata
);

  logic [width_p-1:0] mem_reg [els_p];
  logic [width_p-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < bytes_lp; i++) begin
        if (wmask[i]) mem_reg[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (en && !we) rdata_reg <= mem_reg[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/bp_mem_responder.sv
// Memory-side endpoint: latches one mem_cmd, services it from local block storage,
// and holds the mem_resp until the consumer takes it.
module bp_mem_responder
  import bp_me_pkg::*;
#(
  parameter int          paddr_width_p   = 40,
  parameter int          block_width_p   = 512,
  parameter int          payload_width_p = 16,
  parameter int          mem_els_p       = 256,
  parameter logic [63:0] mem_base_addr_p = '0,
  localparam int cce_mem_msg_width_lp =
    bp_mem_msg_width(paddr_width_p, block_width_p, payload_width_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i
);

  `DECLARE_BP_MEM_IF(paddr_width_p, block_width_p, payload_width_p)

  localparam int block_bytes_lp    = block_width_p / 8;
  localparam int lg_block_bytes_lp = $clog2(block_bytes_lp);
  localparam int lg_els_lp         = $clog2(mem_els_p);
  localparam logic [63:0] mem_bytes_lp = 64'(mem_els_p) * 64'(block_bytes_lp);
  localparam logic [paddr_width_p-1:0] base_lp = paddr_width_p'(mem_base_addr_p);

  bp_mem_msg_s        cmd_in, cmd_reg, resp;
  bp_mem_resp_state_e state_reg;
  logic               ready_reg, resp_v_reg;

  assign cmd_in = mem_cmd_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg  <= e_reset;
      ready_reg  <= 1'b0;
      resp_v_reg <= 1'b0;
      cmd_reg    <= '0;
    end else begin
      case (state_reg)
        e_reset: begin
          state_reg <= e_ready;
          ready_reg <= 1'b1;
        end
        e_ready: if (mem_cmd_v_i) begin
          cmd_reg   <= cmd_in;
          state_reg <= e_access;
          ready_reg <= 1'b0;
        end
        e_access: begin
          state_reg  <= e_resp;
          resp_v_reg <= 1'b1;
        end
        e_resp: if (mem_resp_yumi_i) begin
          state_reg  <= e_ready;
          resp_v_reg <= 1'b0;
          ready_reg  <= 1'b1;
        end
        default: begin
          state_reg  <= e_reset;
          ready_reg  <= 1'b0;
          resp_v_reg <= 1'b0;
        end
      endcase
    end
  end

  // Extra MSB of the subtraction flags addresses below the base.
  logic [paddr_width_p:0]   diff;
  logic [paddr_width_p-1:0] offset;
  logic                     in_range, is_rd, is_wr, rd_hit, wr_hit;
  assign diff     = {1'b0, cmd_reg.addr} - {1'b0, base_lp};
  assign offset   = diff[paddr_width_p-1:0];
  assign in_range = !diff[paddr_width_p] && (64'(offset) < mem_bytes_lp);
  assign is_rd    = (cmd_reg.msg_type == e_mem_msg_rd) || (cmd_reg.msg_type == e_mem_msg_uc_rd);
  assign is_wr    = (cmd_reg.msg_type == e_mem_msg_wr) || (cmd_reg.msg_type == e_mem_msg_uc_wr);
  assign rd_hit   = is_rd && in_range;
  assign wr_hit   = is_wr && in_range;

  // Low bits set below log2(size); saturates to a full block, cached reads always full.
  logic [lg_block_bytes_lp-1:0] size_mask, aligned_off;
  always_comb begin
    size_mask = '0;
    for (int i = 0; i < lg_block_bytes_lp; i++) size_mask[i] = (i < int'(cmd_reg.size));
    if (cmd_reg.msg_type == e_mem_msg_rd) size_mask = '1;
  end
  assign aligned_off = offset[lg_block_bytes_lp-1:0] & ~size_mask;

  logic [block_width_p-1:0]  wdata, rdata, resp_data;
  logic [block_bytes_lp-1:0] wmask;

  for (genvar gi = 0; gi < block_bytes_lp; gi++) begin : g_byte
    localparam logic [lg_block_bytes_lp-1:0] idx_lp = lg_block_bytes_lp'(gi);
    logic [lg_block_bytes_lp-1:0] src_wr, src_rd;
    assign src_wr = idx_lp & size_mask;
    assign src_rd = aligned_off | (idx_lp & size_mask);
    assign wmask[gi] = wr_hit && ((idx_lp & ~size_mask) == aligned_off);
    assign wdata[gi*8 +: 8] = cmd_reg.data[{src_wr, 3'b000} +: 8];
    assign resp_data[gi*8 +: 8] = rd_hit ? rdata[{src_rd, 3'b000} +: 8] : 8'h00;
  end

  bp_mem_responder_storage #(
    .els_p  (mem_els_p),
    .width_p(block_width_p)
  ) storage (
    .clk  (clk_i),
    .en   ((state_reg == e_access) && in_range && (is_rd || is_wr)),
    .we   (is_wr),
    .addr (offset[lg_block_bytes_lp +: lg_els_lp]),
    .wdata(wdata),
    .wmask(wmask),
    .rdata(rdata)
  );

  always_comb begin
    resp      = cmd_reg;
    resp.data = resp_data;
  end

  assign mem_cmd_ready_o = ready_reg;
  assign mem_resp_v_o    = resp_v_reg;
  assign mem_resp_o      = resp_v_reg ? resp : '0;

endmodule

// File: tb/tb_bp_mem_responder.sv
// Scoreboard bench for bp_mem_responder: directed commands push expected responses,
// a negedge monitor pops and compares whenever a new response appears.
module tb_bp_mem_responder;
  localparam int W = 574;
  localparam logic [2:0] RD = 3'd0, WR = 3'd1, UC_RD = 3'd2, UC_WR = 3'd3, PRE = 3'd4;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [2:0]   size;
    logic [15:0]  payload;
    logic [39:0]  addr;
    logic [511:0] data;
  } msg_s;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] cmd = '0;
  logic         cmd_v = 1'b0;
  logic         ready;
  logic [W-1:0] resp;
  logic         resp_v;
  logic         yumi = 1'b0;

  always #5 clk = ~clk;

  bp_mem_responder dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .mem_cmd_i      (cmd),
    .mem_cmd_v_i    (cmd_v),
    .mem_cmd_ready_o(ready),
    .mem_resp_o     (resp),
    .mem_resp_v_o   (resp_v),
    .mem_resp_yumi_i(yumi)
  );

  msg_s exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_taken = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  function automatic msg_s mk(input logic [2:0] t, input logic [2:0] s, input logic [15:0] p,
                              input logic [39:0] a, input logic [511:0] d);
    msg_s m;
    m.msg_type = t; m.size = s; m.payload = p; m.addr = a; m.data = d;
    return m;
  endfunction

  function automatic logic [511:0] pat_inc();
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i);
    return d;
  endfunction

  function automatic logic [511:0] pat_mul3();
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i * 3 + 1);
    return d;
  endfunction

  // Monitor: one comparison per new response.
  always @(negedge clk) begin
    msg_s e;
    if (reset_n && resp_v && !mon_taken) begin
      mon_taken = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp act=%h req=none", resp);
      end else begin
        e = exp_q.pop_front();
        check("resp", resp, e);
        $display("txn type=%0d size=%0d payload=%h addr=%h", e.msg_type, e.size, e.payload, e.addr);
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || (yumi && resp_v)) mon_taken = 1'b0;
  end

  task automatic issue(input msg_s c, input bit push, input msg_s e);
    bit ok;
    @(negedge clk);
    cmd = c;
    cmd_v = 1'b1;
    if (push) exp_q.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("accept", W'(ok), W'(1));
    @(posedge clk);
    #1;
    cmd_v = 1'b0;
    cmd = ~c;
  endtask

  task automatic run(input msg_s c, input msg_s e, input int hold);
    logic [W-1:0] snap;
    issue(c, 1'b1, e);
    @(negedge clk);
    check("resp_v_early", W'(resp_v), W'(0));
    @(negedge clk);
    check("resp_v_n2", W'(resp_v), W'(1));
    snap = resp;
    for (int i = 0; i < hold; i++) begin
      cmd = mk(WR, 3'd6, 16'hDEAD, 40'h40, '1);
      cmd_v = 1'b1;
      check("bp_ready", W'(ready), W'(0));
      check("bp_stable", resp, snap);
      @(negedge clk);
    end
    cmd_v = 1'b0;
    yumi = 1'b1;
    @(posedge clk);
    #1;
    yumi = 1'b0;
    @(negedge clk);
    check("ready_after_yumi", W'(ready), W'(1));
    check("resp_v_after_yumi", W'(resp_v), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    msg_s dummy;
    dummy = '0;

    // Reset
    #1 reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_ready", W'(ready), W'(0));
    check("rst_resp_v", W'(resp_v), W'(0));
    check("rst_resp", resp, '0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", W'(ready), W'(1));

    // Full block write then read
    run(mk(WR, 3'd6, 16'h01A5, 40'h40, pat_inc()), mk(WR, 3'd6, 16'h01A5, 40'h40, '0), 0);
    run(mk(RD, 3'd6, 16'h01A5, 40'h40, '1), mk(RD, 3'd6, 16'h01A5, 40'h40, pat_inc()), 0);

    // Uncached byte write and reads
    run(mk(UC_WR, 3'd0, 16'h0011, 40'h43, {{63{8'h55}}, 8'hEE}), mk(UC_WR, 3'd0, 16'h0011, 40'h43, '0), 0);
    run(mk(UC_RD, 3'd0, 16'h0012, 40'h43, '0), mk(UC_RD, 3'd0, 16'h0012, 40'h43, {64{8'hEE}}), 0);
    d = pat_inc();
    d[31:24] = 8'hEE;
    run(mk(RD, 3'd0, 16'h0013, 40'h40, '0), mk(RD, 3'd0, 16'h0013, 40'h40, d), 0);
    run(mk(UC_RD, 3'd2, 16'h0014, 40'h46, '0), mk(UC_RD, 3'd2, 16'h0014, 40'h46, {16{32'h07060504}}), 0);
    run(mk(UC_RD, 3'd7, 16'h0015, 40'h40, '0), mk(UC_RD, 3'd7, 16'h0015, 40'h40, d), 0);

    // Backpressure
    run(mk(UC_RD, 3'd3, 16'h0016, 40'h40, '0),
        mk(UC_RD, 3'd3, 16'h0016, 40'h40, {8{64'h07060504_EE020100}}), 10);

    // Out of range
    run(mk(WR, 3'd6, 16'h0020, 40'h0, pat_mul3()), mk(WR, 3'd6, 16'h0020, 40'h0, '0), 0);
    run(mk(RD, 3'd6, 16'h0021, 40'h4000, '1), mk(RD, 3'd6, 16'h0021, 40'h4000, '0), 0);
    run(mk(WR, 3'd6, 16'h0022, 40'h4000, '1), mk(WR, 3'd6, 16'h0022, 40'h4000, '0), 0);
    run(mk(RD, 3'd6, 16'h0023, 40'h0, '0), mk(RD, 3'd6, 16'h0023, 40'h0, pat_mul3()), 0);

    // Non-access message
    run(mk(PRE, 3'd6, 16'h0030, 40'h40, '1), mk(PRE, 3'd6, 16'h0030, 40'h40, '0), 0);

    // Reset during access
    run(mk(WR, 3'd6, 16'h0040, 40'h80, {64{8'h5A}}), mk(WR, 3'd6, 16'h0040, 40'h80, '0), 0);
    issue(mk(WR, 3'd6, 16'h0041, 40'h80, {64{8'hC3}}), 1'b0, dummy);
    reset_n = 1'b0;
    #1;
    check("midrst_resp_v", W'(resp_v), W'(0));
    check("midrst_ready", W'(ready), W'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_resp", W'(resp_v), W'(0));
    end
    run(mk(RD, 3'd6, 16'h0042, 40'h80, '0), mk(RD, 3'd6, 16'h0042, 40'h80, {64{8'h5A}}), 0);

    repeat (4) @(negedge clk);
    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_mem_responder.md
Name: bp_mem_responder

Overview:
- Memory-side endpoint of the CCE memory-message interface.
- Accepts mem_cmd messages from the UCE/victim-cache path and services them from a local block-organized, byte-maskable storage array.
- Returns one mem_resp per command.
- Serves as the backing memory for softcore and victim-cache testbenches, and as a small on-chip scratch memory.

Parameters:
- paddr_width_p, 40, physical address width
- block_width_p, 512, cache block width in bits (power of two, ≥64)
- payload_width_p, 16, opaque payload echoed from cmd to resp
- mem_els_p, 256, number of blocks stored (power of two)
- mem_base_addr_p, 0, byte address of block 0 (block-aligned)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- mem_cmd_i  in  cce_mem_msg_width_lp  command {msg_type[3], size[3], payload, addr, data[block_width_p]}
- mem_cmd_v_i  in  1  command valid
- mem_cmd_ready_o  out  1  ready; transfer occurs when v&ready
- mem_resp_o  out  cce_mem_msg_width_lp  response, same packing
- mem_resp_v_o  out  1  response valid
- mem_resp_yumi_i  in  1  consumer takes response; legal only while mem_resp_v_o=1

Behaviour:
- Interface: one clock (clk_i); reset_n_i is asynchronous and active-low.
- Reset: all state registers asynchronously cleared.
  - mem_cmd_ready_o=0 while reset_n_i=0, then 1 on the first cycle after deassertion.
  - mem_resp_v_o=0; mem_resp_o=0.
  - Storage contents are not reset.
- FSM states: e_reset, e_ready, e_access, e_resp.
  - e_reset: entered on reset; exits to e_ready on the next clk_i edge after deassertion.
  - e_ready: mem_cmd_ready_o=1. On v&ready, latch the command and go to e_access.
  - e_access: ready=0. Perform the storage read or write using the latched command; go to e_resp.
  - e_resp: mem_resp_v_o=1 and the response is held stable until mem_resp_yumi_i. On yumi go to e_ready.
- Latency:
  - Command accepted at edge N; response valid in cycle N+2.
  - Throughput is one command per 3 cycles with immediate yumi.
  - No back-to-back accept: ready stays 0 through e_access and e_resp.
- Addressing:
  - offset = addr - mem_base_addr_p.
  - Block index = offset[log2(block_bytes)+:log2(mem_els_p)].
  - Byte offset = offset[log2(block_bytes)-1:0], where block_bytes = block_width_p/8.
- Size: bytes = 1<<size, clamped to block_bytes. Offset is aligned down to the size.
- Read types (e_mem_msg_rd, e_mem_msg_uc_rd):
  - Read the selected bytes.
  - Replicate them across all of resp.data (block_width_p/(8*bytes) copies).
  - For e_mem_msg_rd, size is treated as full block regardless of field.
- Write types (e_mem_msg_wr, e_mem_msg_uc_wr):
  - Write bytes [off, off+bytes) from the low bytes of cmd.data; other bytes are unchanged.
  - resp.data=0.
- Other msg_type values (e.g. e_mem_msg_pre): no storage access; resp.data=0.
- Response header: resp echoes msg_type, size, payload and addr exactly as latched.
- Out-of-range (addr < base or offset ≥ mem_els_p*block_bytes): writes are dropped; reads return all zeros. A response is still produced.
- Ignored inputs:
  - mem_cmd_i is ignored outside the v&ready cycle; the latched copy is used.
  - mem_resp_yumi_i is ignored when mem_resp_v_o=0.
- Reset mid-operation: asynchronously returns to e_reset. An in-flight command is discarded with no response; a partial write either completed at the prior edge or did not occur.

Decomposition:
- bp_me_pkg (shared package):
  - bp_mem_msg_e entries: rd/wr/uc_rd/uc_wr/pre.
  - bp_mem_msg_size_e.
  - Responder state enum.
  - `declare_bp_mem_if struct/width macro, shared with UCE and vcache.
- Sub-module bp_mem_responder_storage: 1-port synchronous RAM, mem_els_p x block_width_p, with per-byte write mask and a 1-cycle read. The top level owns the FSM, masking and replication.

Test Plan:
- Reset: hold reset_n_i=0 for 5 cycles → ready=0 and resp_v=0. Release → ready=1 the next cycle.
- Full block: e_mem_msg_wr addr 0x40, size 64B, data pattern i*0x01 → resp at N+2 with data=0. Then e_mem_msg_rd 0x40 → data returns the pattern; payload 0x1A5 echoed.
- UC byte: e_mem_msg_uc_wr addr 0x43, size 1B, data 0xEE → then uc_rd 0x43 size 1B returns 0xEE replicated 64x. Rd 0x40 shows byte 3=0xEE and other bytes unchanged.
- Backpressure: hold mem_resp_yumi_i=0 for 10 cycles → resp stable, ready=0, and a new cmd is not accepted. Yumi → ready=1 the next cycle.
- Out of range: rd addr = base + mem_els_p*64 → data=0 and a response is still produced. Wr to the same address followed by rd 0x0 → block 0 unchanged.
- Mid-operation reset: assert reset_n_i in e_access → resp_v=0 immediately and no response after release. A following cmd is serviced normally.
